// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage.
// Holds the PC and fetches instructions from a variable-latency req/ack memory.
// Keeps a one-entry fetch buffer {pcPlus1, instruction} for the IF/ID register.
// Honours IF/ID stalls and branch/jump redirects.
module if_fetch_unit #(
    parameter int                  ADDR_W    = 12,
    parameter int                  INSTR_W   = 19,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  pcPlus1_out,
    output logic [INSTR_W-1:0] instruction_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                drop_q, drop_d;
    logic                valid_q, valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pcp1_q, pcp1_d;

    logic                consume;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   req_inc;

    // IF/ID takes the buffer only when it holds something and the hazard unit allows it.
    assign consume = valid_q & pc_write;
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign req_inc = req_addr_q + ADDR_W'(1);

    // Next-state and memory-interface logic; redirect takes priority outside IDLE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pcp1_d     = pcp1_q;
        imem_req   = 1'b0;
        imem_addr  = '0;

        case (state_q)
            S_IDLE: begin
                // One quiet cycle after reset; redirects and acks are ignored here.
                req_addr_d = pc_q;
                state_d    = S_ISSUE;
            end

            S_ISSUE: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                    if (imem_ack) begin
                        // Outstanding request finished this cycle: its data is dropped now.
                        req_addr_d = redirect_pc;
                        drop_d     = 1'b0;
                    end else begin
                        // Keep the address stable until the stale request is acked.
                        drop_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (drop_q) begin
                        drop_d     = 1'b0;
                        req_addr_d = pc_q;
                    end else begin
                        instr_d = imem_rdata;
                        pcp1_d  = req_inc;
                        pc_d    = req_inc;
                        valid_d = 1'b1;
                        state_d = S_STALL;
                    end
                end
            end

            S_STALL: begin
                // Prefetch the next word only when the buffer is being drained.
                imem_req  = consume;
                imem_addr = pc_q;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                    if (consume && !imem_ack) begin
                        drop_d     = 1'b1;
                        req_addr_d = pc_q;
                    end else begin
                        drop_d     = 1'b0;
                        req_addr_d = redirect_pc;
                    end
                end else if (consume) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        pcp1_d  = pc_inc;
                        pc_d    = pc_inc;
                    end else begin
                        // Request stays open; ISSUE keeps presenting the same address.
                        valid_d    = 1'b0;
                        req_addr_d = pc_q;
                        state_d    = S_ISSUE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and fetch-buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pcp1_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pcp1_q     <= pcp1_d;
        end
    end

    assign if_valid        = valid_q;
    assign pcPlus1_out     = pcp1_q;
    assign instruction_out = valid_q ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: latency-programmable memory model plus an in-order
// scoreboard of expected fetch addresses, popped whenever IF/ID consumes the buffer.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [18:0] imem_rdata;
    logic        if_valid;
    logic [11:0] pcPlus1_out;
    logic [18:0] instruction_out;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] seq_next;
    int          lat;
    logic        force_ack;
    int          cnt;
    logic        prev_pend;
    logic [11:0] prev_addr;
    logic [11:0] mon_a;
    logic [11:0] mon_e1;

    if_fetch_unit #(
        .ADDR_W   (12),
        .INSTR_W  (19),
        .RESET_PC (12'h000),
        .NOP_INSTR(19'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .pcPlus1_out    (pcPlus1_out),
        .instruction_out(instruction_out)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        return {a[11:5] ^ 7'h35, a ^ 12'hA5C};
    endfunction

    // Memory model: ack once the request has been held for 'lat' earlier cycles.
    always_comb begin
        imem_ack   = force_ack | (imem_req && (cnt >= lat));
        imem_rdata = mem_word(imem_addr);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst)                      cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else                           cnt <= 0;
    end

    // Scoreboard and request-stability monitor, sampled on the falling edge.
    initial begin
        prev_pend = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (prev_pend) begin
                    checks++;
                    if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL addr_hold: req=%b addr=%h, required req=1 addr=%h",
                                 imem_req, imem_addr, prev_addr);
                    end
                end
                if (if_valid === 1'b1 && pc_write === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_consume: pcPlus1=%h with nothing expected", pcPlus1_out);
                    end else begin
                        mon_a  = exp_q.pop_front();
                        mon_e1 = mon_a + 12'd1;
                        if (pcPlus1_out !== mon_e1 || instruction_out !== mem_word(mon_a)) begin
                            errors++;
                            $display("FAIL scoreboard addr %h: pcPlus1=%h instr=%h, required pcPlus1=%h instr=%h",
                                     mon_a, pcPlus1_out, instruction_out, mon_e1, mem_word(mon_a));
                        end
                    end
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end else begin
                prev_pend = 1'b0;
            end
        end
    end

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq_next);
            seq_next = seq_next + 12'd1;
        end
    endtask

    task automatic drain(input string name, input int bound, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < bound) begin
            @(negedge clk); #1;
            cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d entries left after %0d cycles, required 0", name, exp_q.size(), cycles);
            exp_q.delete();
        end
        @(posedge clk); #1;
        pc_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 12'h000 ||
            pcPlus1_out !== 12'h000 || instruction_out !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b req=%b addr=%h pcp1=%h instr=%h, required all 0",
                     if_valid, imem_req, imem_addr, pcPlus1_out, instruction_out);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: req=%b, required 0", imem_req);
        end
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, required 1 and 000", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (if_valid !== 1'b1 || pcPlus1_out !== 12'h001 || instruction_out !== mem_word(12'h000) ||
            imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_fill: valid=%b pcp1=%h instr=%h req=%b, required 1 001 %h 0",
                     if_valid, pcPlus1_out, instruction_out, imem_req, mem_word(12'h000));
        end
        seq_next = 12'h000;
    endtask

    task automatic test_stream();
        int cyc;
        @(posedge clk); #1;
        push_seq(8);
        pc_write = 1'b1;
        drain("stream", 40, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL stream_throughput: %0d cycles for 8 instrs, required 8", cyc);
        end
    endtask

    task automatic test_latency();
        int cyc;
        @(posedge clk); #1;
        lat = 3;
        push_seq(4);
        pc_write = 1'b1;
        drain("latency", 60, cyc);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL latency_rate: %0d cycles for 4 instrs, required 13", cyc);
        end
    endtask

    task automatic test_stall();
        int  cyc;
        bit  seen;
        logic [11:0] e1;
        @(posedge clk); #1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (if_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_fill_timeout: valid=%b, required 1", if_valid);
        end
        e1 = seq_next + 12'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || pcPlus1_out !== e1 ||
                instruction_out !== mem_word(seq_next)) begin
                errors++;
                $display("FAIL stall_hold: req=%b valid=%b pcp1=%h instr=%h, required 0 1 %h %h",
                         imem_req, if_valid, pcPlus1_out, instruction_out, e1, mem_word(seq_next));
            end
        end
        @(posedge clk); #1;
        push_seq(2);
        pc_write = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== e1) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h, required 1 %h", imem_req, imem_addr, e1);
        end
        drain("stall", 20, cyc);
    endtask

    task automatic test_redirect();
        int cyc;
        bit seen;
        @(posedge clk); #1;
        lat            = 5;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h010;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h010 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_issue: req=%b addr=%h valid=%b, required 1 010 0",
                     imem_req, imem_addr, if_valid);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h0A5;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h010 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_hold_old: req=%b addr=%h valid=%b, required 1 010 0",
                     imem_req, imem_addr, if_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_stale_taken: valid=%b pcp1=%h, required valid 0", if_valid, pcPlus1_out);
            end
            if (imem_req === 1'b1 && imem_addr === 12'h0A5) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL redirect_target_timeout: addr=%h, required 0a5", imem_addr);
        end
        @(posedge clk); #1;
        lat      = 0;
        exp_q.delete();
        seq_next = 12'h0A5;
        push_seq(3);
        pc_write = 1'b1;
        drain("redirect", 20, cyc);
    endtask

    task automatic test_wrap();
        int cyc;
        bit seen;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        seq_next = 12'hFFF;
        seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (if_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || pcPlus1_out !== 12'h000 || instruction_out !== mem_word(12'hFFF)) begin
            errors++;
            $display("FAIL wrap_pcplus1: valid=%b pcp1=%h instr=%h, required 1 000 %h",
                     if_valid, pcPlus1_out, instruction_out, mem_word(12'hFFF));
        end
        @(posedge clk); #1;
        push_seq(3);
        pc_write = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
            errors++;
            $display("FAIL wrap_next_addr: req=%b addr=%h, required 1 000", imem_req, imem_addr);
        end
        drain("wrap", 20, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(posedge clk); #1;
        lat = 4;
        push_seq(1);
        pc_write = 1'b1;
        @(posedge clk); #1;
        pc_write = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== seq_next) begin
            errors++;
            $display("FAIL midreset_pending: req=%b addr=%h, required 1 %h", imem_req, imem_addr, seq_next);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        force_ack = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 12'h000 ||
            pcPlus1_out !== 12'h000 || instruction_out !== 19'h0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b req=%b addr=%h pcp1=%h instr=%h, required all 0",
                     if_valid, imem_req, imem_addr, pcPlus1_out, instruction_out);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: req=%b valid=%b, required 0 0", imem_req, if_valid);
        end
        @(posedge clk); #1;
        force_ack = 1'b0;
        lat       = 0;
        seq_next  = 12'h000;
        push_seq(3);
        pc_write  = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: req=%b addr=%h valid=%b, required 1 000 0",
                     imem_req, imem_addr, if_valid);
        end
        drain("midreset", 20, cyc);
    endtask

    initial begin
        rst            = 1'b0;
        pc_write       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        lat            = 0;
        force_ack      = 1'b0;
        seq_next       = 12'h000;
        test_reset();
        test_stream();
        test_latency();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
